matrix_result_drain: RTL and testbench



---
 rtl/matrix_result_drain.sv | 158 +++++++++++++++
 tb/tb_matrix_result_drain.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_drain.sv
// Result buffer for the 3x3 matrix multiplier: collects nine MAC results by index,
// then drains them in row-major order over a valid/ready handshake and re-arms.
module matrix_result_drain #(
    parameter int DATA_W = 16,
    parameter int N_ELEM = 9,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] res_in,
    input  logic              res_ld,
    input  logic [IDX_W-1:0]  res_sel,
    input  logic              mem_clr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg
);
    // Handshake: an element transfers on every rising edge where out_valid && out_ready;
    // out_data/out_idx are registered and hold steady until that transfer happens.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   buf_q [N_ELEM];
    logic [DATA_W-1:0]   buf_d [N_ELEM];
    logic [N_ELEM-1:0]   mask_q, mask_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (mem_clr) begin
            state_d     = FILL;
            buf_d       = '{default: '0};
            mask_d      = '0;
            ptr_d       = '0;
            err_d       = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = '0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (res_ld) begin
                        if (res_sel <= LAST_IDX) begin
                            buf_d[res_sel]  = res_in;
                            mask_d[res_sel] = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    // Present element 0 from the next-state buffer so a final write to slot 0 is seen.
                    if (mask_d == '1) begin
                        state_d     = DRAIN;
                        ptr_d       = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = buf_d[0];
                        out_idx_d   = '0;
                        busy_d      = 1'b1;
                    end
                end
                DRAIN: begin
                    if (res_ld) err_d = 1'b1;
                    if (out_ready) begin
                        if (ptr_q == LAST_IDX) begin
                            state_d     = DONE;
                            out_valid_d = 1'b0;
                            out_data_d  = '0;
                            out_idx_d   = '0;
                            done_d      = 1'b1;
                        end else begin
                            ptr_d      = ptr_q + 1'b1;
                            out_data_d = buf_q[ptr_q + 1'b1];
                            out_idx_d  = ptr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ld) err_d = 1'b1;
                    state_d = FILL;
                    mask_d  = '0;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d     = FILL;
                    mask_d      = '0;
                    ptr_d       = '0;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    out_idx_d   = '0;
                    busy_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            buf_q       <= '{default: '0};
            mask_q      <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_matrix_result_drain.sv
// Bench for matrix_result_drain: a slot model feeds an expected-element queue that is
// popped as the drain hands elements over.
module tb_matrix_result_drain;
  logic        clk;
  logic        reset;
  logic [15:0] res_in;
  logic        res_ld;
  logic [3:0]  res_sel;
  logic        mem_clr;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  idx_q[$];

  logic [15:0] m_buf[9];
  logic [8:0]  m_mask;
  bit          m_fill;
  bit          m_err;

  matrix_result_drain dut (
    .clk(clk), .reset(reset), .res_in(res_in), .res_ld(res_ld), .res_sel(res_sel),
    .mem_clr(mem_clr), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_buf[i] = 16'h0;
    m_mask = '0;
    m_fill = 1'b1;
    m_err  = 1'b0;
    exp_q.delete();
    idx_q.delete();
  endtask

  // driver: one res_ld cycle; the model decides what the DUT must have done with it
  task automatic load(input logic [3:0] sel, input logic [15:0] val);
    res_ld = 1'b1; res_sel = sel; res_in = val;
    @(posedge clk); #1;
    res_ld = 1'b0;
    if (m_fill) begin
      if (sel < 4'd9) begin
        m_buf[sel]  = val;
        m_mask[sel] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      if (m_mask == 9'h1FF) begin
        for (int i = 0; i < 9; i++) begin
          exp_q.push_back(m_buf[i]);
          idx_q.push_back(i[3:0]);
        end
        m_fill = 1'b0;
      end
    end else begin
      m_err = 1'b1;
    end
    n_cmp++;
    if (out_valid !== !m_fill) begin
      n_bad++; $display("FAIL load_valid sel=%0d: got %b expected %b", sel, out_valid, !m_fill);
    end
    n_cmp++;
    if (err !== m_err) begin
      n_bad++; $display("FAIL load_err sel=%0d: got %b expected %b", sel, err, m_err);
    end
  endtask

  // Drains the queued matrix. mode 0: ready high, 1: ready 1,0,0 repeating, 2: random.
  // inj_at: cycle to fire a stray res_ld to slot 2; abort_at: beat at which mem_clr aborts.
  task automatic drain(input int mode, input int inj_at, input int abort_at);
    int cyc = 0;
    int beats = 0;
    bit stall = 1'b0;
    bit do_inj;
    logic rdy;
    logic [15:0] held = 16'h0;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (beats == abort_at) begin
        out_ready = 1'b0; mem_clr = 1'b1;
        @(posedge clk); #1;
        mem_clr = 1'b0;
        model_clear();
        n_cmp++;
        if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
          n_bad++; $display("FAIL abort_outputs: got v=%b d=%b b=%b expected 0 0 0", out_valid, done, busy);
        end
        n_cmp++;
        if (err !== 1'b0) begin
          n_bad++; $display("FAIL abort_err: got %b expected 0", err);
        end
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      do_inj = (cyc == inj_at);
      if (do_inj) begin
        res_ld = 1'b1; res_sel = 4'd2; res_in = 16'hFFFF;
      end
      n_cmp++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        n_bad++; $display("FAIL drain_valid cyc=%0d: got v=%b b=%b expected 1 1", cyc, out_valid, busy);
      end
      n_cmp++;
      if (out_data !== exp_q[0] || out_idx !== idx_q[0]) begin
        n_bad++;
        $display("FAIL drain_beat cyc=%0d: got %h@%0d expected %h@%0d", cyc, out_data, out_idx, exp_q[0], idx_q[0]);
      end
      if (stall) begin
        n_cmp++;
        if (out_data !== held) begin
          n_bad++; $display("FAIL stall_stable cyc=%0d: got %h expected %h", cyc, out_data, held);
        end
      end
      n_cmp++;
      if (err !== m_err) begin
        n_bad++; $display("FAIL drain_err cyc=%0d: got %b expected %b", cyc, err, m_err);
      end
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++; $display("FAIL early_done cyc=%0d: got %b expected 0", cyc, done);
      end
      if (rdy) begin
        void'(exp_q.pop_front());
        void'(idx_q.pop_front());
        beats++;
      end
      stall = !rdy;
      held = out_data;
      @(posedge clk); #1;
      res_ld = 1'b0;
      if (do_inj) m_err = 1'b1;
      cyc++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
    end
    n_cmp++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL done_pulse: got d=%b v=%b b=%b expected 1 0 1", done, out_valid, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rearm: got d=%b b=%b v=%b expected 0 0 0", done, busy, out_valid);
    end
    n_cmp++;
    if (err !== m_err) begin
      n_bad++; $display("FAIL post_drain_err: got %b expected %b", err, m_err);
    end
    m_fill = 1'b1;
    m_mask = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; res_in = '0; res_ld = 1'b0; res_sel = '0; mem_clr = 1'b0; out_ready = 1'b0;
    model_clear();
    #23;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_idx !== 4'h0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b d=%h i=%h b=%b dn=%b e=%b expected all 0",
               out_valid, out_data, out_idx, busy, done, err);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_in_order();
    for (int i = 0; i < 9; i++) load(i[3:0], 16'h0010 + 16'(i));
    drain(0, -1, -1);
  endtask

  task automatic test_reverse_rewrite();
    for (int i = 8; i >= 1; i--) load(i[3:0], 16'h0100 + 16'(i));
    load(4'd4, 16'hBEEF);
    load(4'd0, 16'h0100);
    drain(0, -1, -1);
  endtask

  task automatic test_back_to_back_backpressure();
    for (int i = 0; i < 9; i++) load(i[3:0], 16'($urandom_range(0, 16'hFFFF)));
    drain(1, -1, -1);
    for (int i = 0; i < 9; i++) load(4'(8 - i), 16'($urandom_range(0, 16'hFFFF)));
    drain(2, -1, -1);
  endtask

  task automatic test_bad_index();
    load(4'd9, 16'h1111);
    load(4'd15, 16'h2222);
    for (int i = 0; i < 9; i++) load(i[3:0], 16'h0300 + 16'(i));
    drain(0, -1, -1);
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    model_clear();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL clr_err: got %b expected 0", err);
    end
  endtask

  task automatic test_ld_in_drain_abort();
    for (int i = 0; i < 9; i++) load(i[3:0], 16'h0200 + 16'(i));
    drain(0, 1, 5);
    for (int i = 0; i < 9; i++) load(i[3:0], 16'h0400 + 16'(i * 7));
    drain(0, -1, -1);
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 9; i++) load(i[3:0], 16'($urandom_range(1, 16'hFFFF)));
    out_ready = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_idx !== 4'h0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b d=%h i=%h b=%b dn=%b e=%b expected all 0",
               out_valid, out_data, out_idx, busy, done, err);
    end
    #3 reset = 1'b0;
    model_clear();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) load(i[3:0], 16'(i * 3 + 1));
    load(4'd8, 16'h5A5A);
    drain(0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reverse_rewrite();
    test_back_to_back_backpressure();
    test_bad_index();
    test_ld_in_drain_abort();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
